// File: rtl/eth_phy_10g_rx_ber_mon_ml_if.sv
// Lane-side bundle between the gearbox/block-lock logic and the multi-lane BER monitor.
// master drives headers, lock and clear; slave (the monitor) returns BER status.
interface eth_phy_10g_rx_ber_mon_ml_if #(
  parameter int LANES         = 1,
  parameter int HDR_WIDTH     = 2,
  parameter int ERR_CNT_WIDTH = 6
);
  logic [LANES*HDR_WIDTH-1:0]     serdes_rx_hdr;
  logic [LANES-1:0]               serdes_rx_hdr_valid;
  logic [LANES-1:0]               rx_block_lock;
  logic                           err_count_clr;
  logic [LANES-1:0]               rx_high_ber;
  logic                           rx_high_ber_any;
  logic [LANES*ERR_CNT_WIDTH-1:0] status_err_count;
  logic                           window_end;

  modport master (
    output serdes_rx_hdr, serdes_rx_hdr_valid, rx_block_lock, err_count_clr,
    input  rx_high_ber, rx_high_ber_any, status_err_count, window_end
  );

  modport slave (
    input  serdes_rx_hdr, serdes_rx_hdr_valid, rx_block_lock, err_count_clr,
    output rx_high_ber, rx_high_ber_any, status_err_count, window_end
  );
endinterface

// File: rtl/eth_phy_10g_rx_ber_mon_ml.sv
// Multi-lane 10G PCS RX BER monitor: per-lane invalid sync-header counting over a shared
// window, registered high-BER flags (1-cycle latency), saturating clearable error counters.
module eth_phy_10g_rx_ber_mon_ml #(
  parameter int LANES         = 1,
  parameter int HDR_WIDTH     = 2,
  parameter int COUNT_125US   = 12500,
  parameter int BER_THRESH    = 16,
  parameter int ERR_CNT_WIDTH = 6
) (
  input logic                        clk,
  input logic                        rst_n,
  eth_phy_10g_rx_ber_mon_ml_if.slave bus
);

  localparam int TW = (COUNT_125US > 1) ? $clog2(COUNT_125US) : 1;
  localparam int BW = $clog2(BER_THRESH + 1);

  localparam logic [TW-1:0]            TIMER_LOAD = TW'(COUNT_125US - 1);
  localparam logic [BW-1:0]            THRESH     = BW'(BER_THRESH);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX    = '1;

  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $error("eth_phy_10g_rx_ber_mon_ml: HDR_WIDTH must be 2");
  end
  if (COUNT_125US < 2) begin : g_bad_count
    $error("eth_phy_10g_rx_ber_mon_ml: COUNT_125US must be >= 2");
  end
  if (BER_THRESH < 1 || BER_THRESH > 255) begin : g_bad_thresh
    $error("eth_phy_10g_rx_ber_mon_ml: BER_THRESH must be 1..255");
  end
  if (ERR_CNT_WIDTH < 1) begin : g_bad_err_width
    $error("eth_phy_10g_rx_ber_mon_ml: ERR_CNT_WIDTH must be >= 1");
  end

  // Shared window timer; window_end is decoded combinationally from the registered count.
  logic [TW-1:0] timer_q, timer_d;
  logic          win_end;

  assign win_end = (timer_q == '0);
  assign timer_d = win_end ? TIMER_LOAD : (timer_q - TW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= TIMER_LOAD;
    end else begin
      timer_q <= timer_d;
    end
  end

  logic [LANES-1:0] hi_d_vec;
  logic [LANES-1:0] hi_q_vec;
  logic             hi_any_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [HDR_WIDTH-1:0]     hdr;
    logic                     lock;
    logic                     inv;
    logic [BW-1:0]            ber_cnt_q, ber_cnt_d, ber_c;
    logic                     hi_q, hi_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

    assign hdr  = bus.serdes_rx_hdr[HDR_WIDTH*i +: HDR_WIDTH];
    assign lock = bus.rx_block_lock[i];
    // Only 2'b01 and 2'b10 are legal sync headers.
    assign inv  = bus.serdes_rx_hdr_valid[i] & lock & (hdr[1] ~^ hdr[0]);

    assign ber_c = (ber_cnt_q == THRESH) ? THRESH : (ber_cnt_q + BW'(inv));

    // Reaching threshold wins over the window-end clear so a hit on the last cycle still flags.
    always_comb begin
      ber_cnt_d = ber_c;
      hi_d      = hi_q;
      if (!lock) begin
        ber_cnt_d = '0;
        hi_d      = 1'b0;
      end else begin
        if (win_end) begin
          ber_cnt_d = '0;
        end
        if (ber_c == THRESH) begin
          hi_d = 1'b1;
        end else if (win_end) begin
          hi_d = 1'b0;
        end
      end
    end

    always_comb begin
      err_d = err_q;
      if (bus.err_count_clr) begin
        err_d = ERR_CNT_WIDTH'(inv);
      end else if (inv && (err_q != ERR_MAX)) begin
        err_d = err_q + ERR_CNT_WIDTH'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ber_cnt_q <= '0;
        hi_q      <= 1'b0;
        err_q     <= '0;
      end else begin
        ber_cnt_q <= ber_cnt_d;
        hi_q      <= hi_d;
        err_q     <= err_d;
      end
    end

    assign hi_d_vec[i] = hi_d;
    assign hi_q_vec[i] = hi_q;
    assign bus.status_err_count[i*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = err_q;
  end

  // Registered from the next-state flags so it lines up with rx_high_ber.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_any_q <= 1'b0;
    end else begin
      hi_any_q <= |hi_d_vec;
    end
  end

  assign bus.rx_high_ber     = hi_q_vec;
  assign bus.rx_high_ber_any = hi_any_q;
  assign bus.window_end      = win_end;

endmodule

// File: doc/eth_phy_10g_rx_ber_mon_ml.md
Name: eth_phy_10g_rx_ber_mon_ml

Overview:
Multi-lane, parametrised bit-error-rate (BER) monitor for the 10G PCS receive path.
- Checks the 2-bit sync header of each lane every cycle.
- Counts invalid headers per lane inside a shared window (125 us by default).
- Raises a per-lane high-BER flag when a programmable threshold is reached.
- Keeps a saturating per-lane error counter, cleared by a pulse, for status readout.
- Sits between the per-lane gearbox/block-lock logic and the PCS status/management block.

Parameters:
LANES, 1, number of independent receive lanes
HDR_WIDTH, 2, sync header width per lane; must be 2, elaboration error otherwise
COUNT_125US, 12500, window length in clk cycles; must be >= 2
BER_THRESH, 16, invalid headers per window that assert high BER; 1..255
ERR_CNT_WIDTH, 6, width of each per-lane saturating error counter; >= 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
serdes_rx_hdr  in  LANES*HDR_WIDTH  per-lane sync header; lane i occupies bits [2i+1:2i]
serdes_rx_hdr_valid  in  LANES  lane i header is present this cycle (gearbox slip gaps deasserted)
rx_block_lock  in  LANES  lane i block lock achieved
err_count_clr  in  1  single-cycle pulse that clears all error counters
rx_high_ber  out  LANES  per-lane high-BER flag
rx_high_ber_any  out  1  OR of rx_high_ber
status_err_count  out  LANES*ERR_CNT_WIDTH  per-lane saturating invalid-header count; lane i at [i*W +: W]
window_end  out  1  one-cycle pulse on the last cycle of each window

Behaviour:
- Reset: asynchronous on rst_n low, released synchronously by the integrator.
  - Timer loads COUNT_125US-1.
  - All ber_cnt are 0.
  - rx_high_ber, rx_high_ber_any, status_err_count and window_end are all 0.
- Valid headers are 2'b01 (control) and 2'b10 (data). Headers 2'b00 and 2'b11 are invalid.
- Counted event for lane i (inv[i]): serdes_rx_hdr_valid[i] and rx_block_lock[i] and header invalid.
- Shared timer, width $clog2(COUNT_125US):
  - Decrements every cycle.
  - When it is 0: the current cycle is the window end. window_end=1 that cycle (combinational from the timer value, registered timer). Next cycle the timer reloads COUNT_125US-1.
  - Window length is exactly COUNT_125US cycles.
- Per-lane ber_cnt, width $clog2(BER_THRESH+1), saturates at BER_THRESH:
  - c = min(ber_cnt + inv[i], BER_THRESH).
  - ber_cnt_next = 0 if window_end, else c.
  - hi_next = 1 if c == BER_THRESH; else 0 if window_end; else current rx_high_ber[i].
  - An invalid header on the window-end cycle counts toward the closing window.
  - rx_high_ber[i] rises the cycle after the BER_THRESH-th invalid header.
  - Once set, rx_high_ber[i] stays high through the rest of that window. At the window end it clears only if that window ended with fewer than BER_THRESH events, so it persists while every window reaches threshold.
- Lock loss: while rx_block_lock[i]=0, lane i has ber_cnt forced to 0 and rx_high_ber[i] forced to 0 (registered, one-cycle latency). The timer keeps running.
- serdes_rx_hdr_valid[i]=0: the lane is frozen (no event) but is still subject to window_end clearing.
- status_err_count lane i:
  - Increments on inv[i] and saturates at 2^ERR_CNT_WIDTH-1.
  - err_count_clr with a simultaneous inv[i] gives a result of 1. Clear alone gives 0.
  - Not affected by windows or lock loss.
- rx_high_ber_any is registered: the OR of the hi_next values, so it is coincident with rx_high_ber.
- Lanes are fully independent except for the shared timer and err_count_clr.

Test Plan (LANES=2, COUNT_125US=100, BER_THRESH=16, ERR_CNT_WIDTH=6 unless noted):
1. Reset, then 300 cycles of 2'b10 on both lanes, all locked and valid -> rx_high_ber=0 throughout; window_end pulses at cycles 99, 199, 299 after reset release; status_err_count=0.
2. Lane0 gets 16 headers of 2'b00 at cycles 10..25 -> rx_high_ber[0]=1 from cycle 26 and rx_high_ber_any=1; lane1 stays 0; status_err_count lane0=16; after a clean next window, rx_high_ber[0] clears the cycle after window_end (cycle 200).
3. Lane1 gets 15 invalid headers per window for 3 windows -> rx_high_ber[1] never asserts; ber_cnt returns to 0 after each window_end.
4. Lane0 gets 15 invalid headers at cycles 80..94 plus its 16th on cycle 99 (window end) -> rx_high_ber[0]=1 at cycle 100 and stays 1 through the next window even if clean, then clears at cycle 200.
5. Lane0 high-BER set, then rx_block_lock[0] deasserted for 1 cycle -> rx_high_ber[0]=0 on the following cycle; 10 invalid headers while unlocked or with serdes_rx_hdr_valid=0 -> no count change.
6. ERR_CNT_WIDTH=3: 9 invalid headers -> status_err_count lane0 saturates at 7; err_count_clr pulsed together with an invalid header -> 1; err_count_clr alone -> 0; rst_n asserted mid-window -> all outputs 0 immediately, before the next clk edge.
